// File: rtl/float_decoder.sv
// Serial float-to-fixed decoder: sign/exponent/significand word in,
// exact two's-complement integer out, one left shift per clock.
module float_decoder #(
   parameter int EXP_W = 3,
   parameter int SIG_W = 4,
   parameter int OUT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [SIG_W-1:0] in_sig,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SIGN  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_sign;
   logic               w_sign_nxt;
   logic [OUT_W-1:0]   r_mag;
   logic [OUT_W-1:0]   w_mag_nxt;
   logic [EXP_W-1:0]   r_cnt;
   logic [EXP_W-1:0]   w_cnt_nxt;
   logic [OUT_W-1:0]   r_data;
   logic [OUT_W-1:0]   w_data_nxt;
   logic               r_valid;
   logic               w_valid_nxt;

   // Next-state and datapath decode for the accept/shift/sign/handshake sequence.
   always_comb begin
      w_state_nxt = r_state;
      w_sign_nxt  = r_sign;
      w_mag_nxt   = r_mag;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_sign_nxt  = in_sign;
               w_mag_nxt   = OUT_W'(in_sig);
               w_cnt_nxt   = in_exp;
               w_state_nxt = SHIFT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (r_cnt != {EXP_W{1'b0}}) begin
               w_mag_nxt   = {r_mag[OUT_W-2:0], 1'b0};
               w_cnt_nxt   = r_cnt - EXP_W'(1);
               w_state_nxt = SHIFT;
            end else begin
               w_state_nxt = SIGN;
            end
         end
         SIGN: begin
            // Negating a zero magnitude wraps back to zero, so no negative zero.
            w_data_nxt  = r_sign ? (~r_mag + OUT_W'(1)) : r_mag;
            w_valid_nxt = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = DONE;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sign  <= 1'b0;
         r_mag   <= {OUT_W{1'b0}};
         r_cnt   <= {EXP_W{1'b0}};
         r_data  <= {OUT_W{1'b0}};
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sign  <= w_sign_nxt;
         r_mag   <= w_mag_nxt;
         r_cnt   <= w_cnt_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign out_valid = r_valid;
   assign out_data  = r_data;

endmodule

// File: tb/tb_float_decoder.sv
// Scoreboard bench for float_decoder: driver pushes expected value/latency,
// monitor pops and compares on each rising out_valid.
module tb_float_decoder;
   localparam int EXP_W = 3;
   localparam int SIG_W = 4;
   localparam int OUT_W = 12;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_sign = 1'b0;
   logic [EXP_W-1:0] in_exp = '0;
   logic [SIG_W-1:0] in_sig = '0;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             busy;

   float_decoder #(.EXP_W(EXP_W), .SIG_W(SIG_W), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [OUT_W-1:0] data;
      int               acc;
      int               lat;
   } exp_t;
   exp_t sb_q[$];

   int n_pass = 0;
   int n_chk  = 0;
   logic rnd_mode = 1'b0;
   logic or_val   = 1'b1;

   // Reference: signed integer value, then kept to OUT_W two's-complement bits.
   function automatic logic [OUT_W-1:0] ref_val(input logic s, input int e, input int m);
      int v;
      v = m * (1 << e);
      if (s) v = -v;
      return v[OUT_W-1:0];
   endfunction

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                    name, got, got, want, want, cyc);
   endtask

   task automatic send(input logic s, input int e, input int m, input logic [OUT_W-1:0] want);
      int t;
      exp_t x;
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = EXP_W'(e);
      in_sig   = SIG_W'(m);
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      x.data = want;
      x.acc  = cyc;
      x.lat  = e + 2;
      sb_q.push_back(x);
      in_valid = 1'b0;
      in_sign  = 1'($urandom);
      in_exp   = EXP_W'($urandom);
      in_sig   = SIG_W'($urandom);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || out_valid) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", sb_q.size(), 0);
   endtask

   // Downstream ready: fixed level or random backpressure.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : or_val;
      end
   end

   // Monitor: compare every new result against the scoreboard head.
   initial begin
      logic prev;
      logic [OUT_W-1:0] held;
      exp_t cur;
      prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid && !prev) begin
               chk("expected_pending", int'(sb_q.size() > 0), 1);
               if (sb_q.size() > 0) begin
                  cur = sb_q.pop_front();
                  chk("data", out_data, cur.data);
                  chk("latency", cyc - cur.acc, cur.lat);
                  held = cur.data;
               end
            end else if (out_valid && prev) begin
               chk("hold_data", out_data, held);
            end
            if (sb_q.size() > 0) begin
               chk("busy_inflight", busy, 1);
               chk("in_ready_inflight", in_ready, 0);
            end
         end
         prev = out_valid;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int order[256];
      int tmp, j, w, t;
      logic [OUT_W-1:0] want;

      // Reset values
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Directed words with known constants
      send(1'b0, 2, 11, 12'h02C);
      send(1'b1, 7, 15, 12'h880);
      send(1'b1, 0, 0, 12'h000);
      drain();

      // Backpressure with in_valid toggling while DONE
      @(posedge clk);
      #1 or_val = 1'b0;
      want = ref_val(1'b0, 3, 5);
      send(1'b0, 3, 5, want);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("bp_valid_seen", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         in_sign  = 1'($urandom);
         in_exp   = EXP_W'($urandom);
         in_sig   = SIG_W'($urandom);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_data", out_data, want);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1 or_val = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_idle_out_valid", out_valid, 0);
      chk("bp_idle_busy", busy, 0);
      chk("bp_retain_data", out_data, want);
      drain();

      // Reset in the middle of SHIFT
      send(1'b0, 5, 9, ref_val(1'b0, 5, 9));
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_busy", busy, 0);
      @(posedge clk);
      #1;
      chk("mid_rst_hold_ready", in_ready, 1);
      #1 rst_n = 1'b1;
      send(1'b0, 1, 3, 12'h006);
      drain();

      // Exhaustive sweep, shuffled
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         tmp = order[i];
         order[i] = order[j];
         order[j] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
         w = order[i];
         send(w[7], (w >> 4) & 7, w & 15, ref_val(w[7], (w >> 4) & 7, w & 15));
      end
      drain();

      // Random words under random backpressure
      rnd_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         w = int'($urandom_range(0, 255));
         send(w[7], (w >> 4) & 7, w & 15, ref_val(w[7], (w >> 4) & 7, w & 15));
      end
      drain();
      rnd_mode = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/float_decoder.md
FLOAT_DECODER -- requirements
Module: float_decoder

Interface
REQ-001 Parameters SHALL be: EXP_W, default 3, exponent width; SIG_W, default 4, significand width; OUT_W, default 12, two's-complement output width.
REQ-002 Parameter legality SHALL be OUT_W >= SIG_W + (2**EXP_W - 1) + 1; elaboration with an illegal set is unsupported.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream float word present.
REQ-007 in_ready  output  1  decoder able to accept a word.
REQ-008 in_sign  input  1  sign, 1 = negative.
REQ-009 in_exp  input  EXP_W  unsigned exponent.
REQ-010 in_sig  input  SIG_W  unsigned significand, no hidden bit.
REQ-011 out_valid  output  1  out_data holds a decoded result.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_data  output  OUT_W  two's-complement value.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Decoded value SHALL be (in_sign ? -1 : +1) * in_sig * 2**in_exp, exact, with no rounding or saturation.
REQ-016 FSM states SHALL be IDLE, SHIFT, SIGN and DONE, and no others.
REQ-017 in_ready SHALL be 1 only in IDLE; an accept is in_valid && in_ready at a rising edge.
REQ-018 On accept, the block SHALL capture in_sign, in_sig zero-extended to OUT_W bits (mag) and in_exp (cnt), then enter SHIFT.
REQ-019 In SHIFT, if cnt != 0 the block SHALL shift mag left by 1, decrement cnt and stay in SHIFT; if cnt == 0 it SHALL go to SIGN.
REQ-020 In SIGN, the block SHALL load out_data with sign ? (~mag + 1) : mag, set out_valid and go to DONE.
REQ-021 A magnitude of 0 with sign 1 SHALL produce 0 (no negative zero).
REQ-022 Latency SHALL be in_exp + 2 cycles, from the accept edge to the edge that raises out_valid (2 to 9 cycles at defaults).
REQ-023 In DONE, out_valid and out_data SHALL hold stable until out_valid && out_ready at an edge; that edge SHALL clear out_valid and return to IDLE.
REQ-024 in_valid while not in IDLE SHALL be ignored; no input is queued, and upstream must hold the word.
REQ-025 Input changes after the accept edge SHALL NOT affect the result in flight.
REQ-026 Maximum throughput SHALL be one word per in_exp + 4 cycles: accept, shifts, SIGN, DONE handshake, then IDLE.
REQ-027 out_data SHALL retain its last value after the DONE handshake until the next SIGN state.
REQ-028 Arithmetic SHALL be unsigned on mag and cnt; the negate SHALL be performed in OUT_W bits.

Reset
REQ-029 While rst_n = 0, the block SHALL be in state IDLE with in_ready = 1, out_valid = 0, out_data = 0, busy = 0, mag = 0 and cnt = 0.
REQ-030 Reset assertion in any state, including mid-SHIFT or in DONE, SHALL abort the word with no partial result emitted.
REQ-031 After rst_n deasserts, the first accept SHALL be possible at the first rising edge.

Verification
REQ-032 Scenario: sign=0, exp=3'b010, sig=4'b1011, out_ready=1 -> out_data=12'h02C (44), out_valid rises 4 cycles after accept.
REQ-033 Scenario: sign=1, exp=3'b111, sig=4'b1111 -> out_data=12'h880 (-1920) after 9 cycles; busy=1 throughout.
REQ-034 Scenario: sign=1, exp=3'b000, sig=4'b0000 -> out_data=12'h000, 2-cycle latency.
REQ-035 Scenario: out_ready=0 for 5 cycles after out_valid, with in_valid toggling meanwhile -> out_data held, in_ready=0, no second accept; out_ready=1 -> IDLE on the next cycle.
REQ-036 Scenario: rst_n pulsed low during SHIFT of exp=5 -> out_valid never rises for that word, in_ready=1 during reset, and a subsequent word (sign=0, exp=1, sig=3) gives 12'h006.
REQ-037 Scenario: an exhaustive sweep of all 256 input words with out_ready=1 -> every out_data equals the REQ-015 reference and every latency equals REQ-022.
